// File: rtl/simprisc_pkg.sv
// rtl/simprisc_pkg.sv - shared LSU types, data width and lane helpers
package simprisc_pkg;

   localparam int MEM_DW = 32;

   typedef enum logic [1:0] {
      SZ_B    = 2'd0,
      SZ_H    = 2'd1,
      SZ_W    = 2'd2,
      SZ_RSVD = 2'd3
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   // Low address bits that are meaningful for an access of the given size.
   function automatic logic [1:0] align_off(input lsu_size_e size, input logic [1:0] off);
      case (size)
         SZ_B:    return off;
         SZ_H:    return {off[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
      return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_master_if.sv
// rtl/lsu_master_if.sv - core request/response and unified-memory port bundle
interface lsu_master_if;
   import simprisc_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [31:0]       mem_addr;
   logic [MEM_DW-1:0] mem_wdata;
   logic              mem_rw;
   logic [MEM_DW-1:0] mem_rdata;

   modport master (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_rw
   );

   modport slave (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_rw
   );

endinterface

// File: rtl/lsu_lane_mux.sv
// rtl/lsu_lane_mux.sv - byte/half lane extract for loads and read-modify-write merge for stores
module lsu_lane_mux
   import simprisc_pkg::*;
(
   input  lsu_size_e         size,
   input  logic [1:0]        off,
   input  logic              sign_ext,
   input  logic [MEM_DW-1:0] rword,
   input  logic [MEM_DW-1:0] wdata,
   output logic [MEM_DW-1:0] load_data,
   output logic [MEM_DW-1:0] merge_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rword[{off, 3'b000} +: 8];
      half_sel = off[1] ? rword[31:16] : rword[15:0];

      case (size)
         SZ_B:    load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         SZ_H:    load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
         default: load_data = rword;
      endcase

      merge_data = rword;
      case (size)
         SZ_B: merge_data[{off, 3'b000} +: 8] = wdata[7:0];
         SZ_H: begin
            if (off[1]) merge_data[31:16] = wdata[15:0];
            else        merge_data[15:0]  = wdata[15:0];
         end
         default: merge_data = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - load/store unit driving a word-wide unified memory port
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of truncating the address.
module lsu_master
   import simprisc_pkg::*;
#(
   parameter int MEM_RD_LAT = 1
)
(
   input  logic         clk,
   input  logic         nreset,
   lsu_master_if.master bus
);

   localparam logic [1:0] RD_LAST = 2'(MEM_RD_LAT);

   lsu_state_e        state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   lsu_size_e         size_q, size_d;
   logic              sgn_q, sgn_d;
   logic [1:0]        off_q, off_d;
   logic [MEM_DW-1:0] wdata_q, wdata_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [MEM_DW-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_rw_q, mem_rw_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;

   lsu_size_e         req_size_e;
   logic              req_reject;
   logic [MEM_DW-1:0] load_data;
   logic [MEM_DW-1:0] merge_data;

   assign req_size_e = lsu_size_e'(bus.req_size);

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_reject = (req_size_e == SZ_RSVD) || is_misaligned(req_size_e, bus.req_addr[1:0]);
`else
   assign req_reject = (req_size_e == SZ_RSVD);
`endif

   assign bus.req_ready  = (state_q == IDLE) && !nreset;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_rw     = mem_rw_q;

   lsu_lane_mux u_lane_mux (
      .size       (size_q),
      .off        (off_q),
      .sign_ext   (sgn_q),
      .rword      (bus.mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      size_d       = size_q;
      sgn_d        = sgn_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_rw_d     = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid && bus.req_ready) begin
               we_d    = bus.req_we;
               size_d  = req_size_e;
               sgn_d   = bus.req_signed;
               off_d   = align_off(req_size_e, bus.req_addr[1:0]);
               wdata_d = bus.req_wdata;
               cnt_d   = 2'd0;
               if (req_reject) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  mem_addr_d = {bus.req_addr[31:2], 2'b00};
                  if (bus.req_we && (req_size_e == SZ_W)) begin
                     state_d     = WR;
                     mem_wdata_d = bus.req_wdata;
                     mem_rw_d    = 1'b1;
                  end else begin
                     state_d = RD;
                  end
               end
            end
         end
         RD: begin
            // Read data is sampled on the edge closing the last RD cycle.
            if (cnt_q == RD_LAST) begin
               if (we_q) begin
                  state_d     = WR;
                  mem_wdata_d = merge_data;
                  mem_rw_d    = 1'b1;
               end else begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = load_data;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (nreset) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         we_q         <= 1'b0;
         size_q       <= SZ_B;
         sgn_q        <= 1'b0;
         off_q        <= 2'b00;
         wdata_q      <= '0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= '0;
         mem_rw_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         size_q       <= size_d;
         sgn_q        <= sgn_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_rw_q     <= mem_rw_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_master.sv
// tb/tb_lsu_master.sv - directed bench for lsu_master with a one-cycle-latency memory model
module tb_lsu_master;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   lsu_master_if bus ();

   lsu_master #(.MEM_RD_LAT(1)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   logic [31:0] mem [0:63];
   logic [31:0] rdata_q = 32'h0;
   logic        pre_we = 1'b0;
   logic [5:0]  pre_idx = 6'd0;
   logic [31:0] pre_data = 32'h0;
   int          wr_count = 0;
   int          resp_cnt = 0;
   logic [31:0] last_waddr = 32'h0;
   logic [31:0] last_wdata = 32'h0;

   assign bus.mem_rdata = rdata_q;

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_idx] <= pre_data;
      end else if (bus.mem_rw) begin
         mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
         wr_count   <= wr_count + 1;
         last_waddr <= bus.mem_addr;
         last_wdata <= bus.mem_wdata;
      end
      rdata_q <= mem[bus.mem_addr[7:2]];
      if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      pre_we   = 1'b1;
      pre_idx  = addr[7:2];
      pre_data = data;
      @(posedge clk); #1;
      pre_we   = 1'b0;
   endtask

   task automatic run(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
      int          lat;
      logic [31:0] rd;
      logic        er;
      lat = 0;
      rd  = 'x;
      er  = 1'bx;
      chk({tag, ".ready_idle"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk); #1;
      bus.req_valid  = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (bus.resp_valid) begin
            lat = i;
            rd  = bus.resp_rdata;
            er  = bus.resp_err;
            break;
         end
         @(posedge clk); #1;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".rdata"}, rd, exp_rdata);
      chk({tag, ".err"}, 32'(er), 32'(exp_err));
      chk({tag, ".ready_resp"}, 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      chk({tag, ".valid_drop"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, ".ready_after"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      int wr0;
      int resp0;
      nreset         = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst.resp_err",   32'(bus.resp_err),   32'd0);
      chk("rst.resp_rdata", bus.resp_rdata,      32'h0);
      chk("rst.mem_rw",     32'(bus.mem_rw),     32'd0);
      chk("rst.mem_addr",   bus.mem_addr,        32'h0);
      chk("rst.mem_wdata",  bus.mem_wdata,       32'h0);
      chk("rst.req_ready",  32'(bus.req_ready),  32'd0);
      nreset = 1'b0;
      #1;

      preload(32'h40, 32'hDEADBEEF);
      run("ld_word", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, 1'b0);
      chk("ld_word.mem_addr", bus.mem_addr, 32'h40);

      preload(32'h40, 32'h80FF0011);
      run("ld_sb43", 1'b0, 2'd0, 1'b1, 32'h43, 32'h0, 3, 32'hFFFFFF80, 1'b0);
      run("ld_ub43", 1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 3, 32'h00000080, 1'b0);
      run("ld_sh42", 1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 3, 32'hFFFF80FF, 1'b0);
      run("ld_ub41", 1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 3, 32'h00000000, 1'b0);
      run("ld_sb40", 1'b0, 2'd0, 1'b1, 32'h40, 32'h0, 3, 32'h00000011, 1'b0);

      preload(32'h40, 32'h11223344);
      wr0 = wr_count;
      run("st_h42", 1'b1, 2'd1, 1'b0, 32'h42, 32'h5555AAAA, 4, 32'h0, 1'b0);
      chk("st_h42.writes", 32'(wr_count - wr0), 32'd1);
      chk("st_h42.waddr", last_waddr, 32'h40);
      chk("st_h42.wdata", last_wdata, 32'hAAAA3344);

      wr0 = wr_count;
      run("st_b41", 1'b1, 2'd0, 1'b0, 32'h41, 32'hFFFFFF5A, 4, 32'h0, 1'b0);
      chk("st_b41.writes", 32'(wr_count - wr0), 32'd1);
      chk("st_b41.wdata", last_wdata, 32'hAAAA5A44);

      wr0 = wr_count;
      run("st_w48", 1'b1, 2'd2, 1'b0, 32'h48, 32'h12345678, 2, 32'h0, 1'b0);
      chk("st_w48.writes", 32'(wr_count - wr0), 32'd1);
      chk("st_w48.waddr", last_waddr, 32'h48);
      chk("st_w48.wdata", last_wdata, 32'h12345678);
      run("ld_w48", 1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 3, 32'h12345678, 1'b0);

      wr0 = wr_count;
      run("rsvd", 1'b1, 2'd3, 1'b0, 32'h40, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
      chk("rsvd.writes", 32'(wr_count - wr0), 32'd0);
      chk("rsvd.mem_addr", bus.mem_addr, 32'h48);

`ifdef LSU_MISALIGN_TRAP_EN
      run("ld_w41", 1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 1, 32'h0, 1'b1);
      chk("ld_w41.mem_addr", bus.mem_addr, 32'h48);
`else
      run("ld_w41", 1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 3, 32'hAAAA5A44, 1'b0);
      chk("ld_w41.mem_addr", bus.mem_addr, 32'h40);
`endif

      preload(32'h40, 32'h11223344);
      wr0   = wr_count;
      resp0 = resp_cnt;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h40;
      bus.req_wdata  = 32'h000000EE;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      nreset        = 1'b1;
      @(posedge clk); #1;
      nreset = 1'b0;
      #1;
      chk("rst_rd.req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rd.mem_rw",    32'(bus.mem_rw),    32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("rst_rd.writes", 32'(wr_count - wr0), 32'd0);
      chk("rst_rd.resps",  32'(resp_cnt - resp0), 32'd0);
      chk("rst_rd.mem",    mem[16], 32'h11223344);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 SHALL have parameter MEM_RD_LAT, default 1, range 1..3: cycles from mem_addr first stable (mem_rw=0) to mem_rdata valid.
REQ-002 SHALL have ports as follows (clock and reset first):
  clk  in  1  single clock, all state on rising edge
  nreset  in  1  reset; synchronous, active-high (1 = reset)
  req_valid  in  1  core access request
  req_ready  out  1  lsu can accept request
  req_we  in  1  1 = store, 0 = load
  req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
  req_signed  in  1  sign-extend sub-word load
  req_addr  in  32  byte address
  req_wdata  in  32  store data, low-aligned
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  32  load result, zero when not a load
  resp_err  out  1  access rejected, valid with resp_valid
  mem_addr  out  32  word-aligned byte address, bits[1:0] = 0
  mem_wdata  out  32  full-word write data
  mem_rw  out  1  1 = write committed at this edge, 0 = read
  mem_rdata  in  32  memory read word

Function
REQ-003 SHALL act as the initiator side of the unified-memory port, issuing word-wide reads and writes with no byte enables.
REQ-004 SHALL implement states IDLE, RD, WR, RESP, driving all mem_* and resp_* outputs from registers only.
REQ-005 SHALL assert req_ready only in IDLE; a request is accepted on an edge with req_valid && req_ready, capturing all req_* fields.
REQ-006 Word load: IDLE->RD; RD holds mem_addr, mem_rw=0 for MEM_RD_LAT+1 cycles, captures mem_rdata at the end of the last RD cycle; ->RESP.
REQ-007 Word store: IDLE->WR; WR lasts exactly one cycle with mem_rw=1, mem_wdata=req_wdata; ->RESP.
REQ-008 Sub-word store: IDLE->RD (read, as REQ-006) ->WR, writing the read word with only the addressed byte/half lane replaced by req_wdata[7:0]/[15:0]; ->RESP.
REQ-009 Sub-word load: SHALL extract the lane selected by addr[1:0] (byte) or addr[1] (half), and zero- or sign-extend it per req_signed.
REQ-010 RESP SHALL last one cycle with resp_valid=1, then ->IDLE; resp_valid has no backpressure.
REQ-011 Latency from accept edge to resp_valid cycle: load MEM_RD_LAT+2; word store 2; sub-word store MEM_RD_LAT+3; rejected access 1.
REQ-012 req_size=3 SHALL be rejected: IDLE->RESP, resp_err=1, no mem_rw pulse, regardless of configuration.
REQ-013 mem_rw SHALL be 1 only in WR; mem_addr and mem_wdata SHALL be stable for the whole RD/WR sequence of one access.
REQ-014 req_valid while req_ready=0 SHALL be ignored; the earliest next accept is the edge ending the cycle after resp_valid.

Reset
REQ-015 With nreset=1 at an edge: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_rw=0, mem_addr=0, mem_wdata=0; req_ready=0 while nreset=1.
REQ-016 Reset mid-access SHALL abandon the access with no resp_valid; a store already in WR commits at that edge, and no further write is issued.

Configuration
REQ-017 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> IDLE->RESP, resp_err=1, no memory access.
REQ-018 Macro LSU_MISALIGN_TRAP_EN undefined: offending low address bits are ignored (forced to 0 for that size), the access proceeds, and resp_err is set only per REQ-012.

Structure
REQ-019 Package simprisc_pkg SHALL hold lsu_size_e (SZ_B, SZ_H, SZ_W, SZ_RSVD), lsu_state_e, and the constant MEM_DW=32.
REQ-020 Lane extract/merge logic SHALL be in combinational sub-module lsu_lane_mux, instantiated once.

Verification
REQ-021 Word load, addr 0x40, mem word 0xDEADBEEF, MEM_RD_LAT=1 -> resp_valid 3 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-022 Signed byte load, addr 0x43, word 0x80FF0011 -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-023 Half store 0xAAAA to 0x42 over word 0x11223344 -> single mem_rw pulse writing 0xAAAA3344, resp_valid at accept+4.
REQ-024 Word load to 0x41: with LSU_MISALIGN_TRAP_EN -> resp_err=1 at accept+1, no read issued; without it -> read of 0x40, resp_err=0.
REQ-025 nreset pulsed during RD of a byte store -> no mem_rw pulse, no resp_valid, req_ready=1 the cycle after nreset falls.
